rename_map_table: RTL and testbench
===================================

RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 The module SHALL have parameters: AREG_WIDTH=5 (arch index width); NUM_AREG=32; PREG_WIDTH=6 (phys tag width); NUM_PREG=64; DATA_WIDTH=32; NUM_WB=2 (writeback ports).
REQ-002 The module SHALL have these ports, one per line as name direction width meaning:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- rs1_idx, rs2_idx  in  AREG_WIDTH  source arch indices.
- rd_idx  in  AREG_WIDTH  destination arch index.
- rename_valid  in  1  rename rd_idx to rd_new_tag this cycle.
- rd_new_tag  in  PREG_WIDTH  freshly allocated phys tag.
- rs1_tag, rs2_tag, rd_old_tag  out  PREG_WIDTH  speculative mappings.
- rs1_ready, rs2_ready  out  1  source value available.
- rs1_data, rs2_data  out  DATA_WIDTH  source values.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_tag  in  NUM_WB*PREG_WIDTH  packed writeback tags, port 0 in LSBs.
- wb_data  in  NUM_WB*DATA_WIDTH  packed writeback data, port 0 in LSBs.
- commit_valid  in  1  retire one mapping.
- commit_idx  in  AREG_WIDTH  retiring arch index.
- commit_tag  in  PREG_WIDTH  retiring phys tag.
- commit_old_tag  out  PREG_WIDTH  prior committed tag of commit_idx (to free list).
- flush  in  1  restore speculative map from committed map.

Function
REQ-003 The module SHALL hold a speculative map (NUM_AREG x PREG_WIDTH), a committed map (same), a ready bit per phys tag, and a data word per phys tag (NUM_PREG x DATA_WIDTH).
REQ-004 Reads SHALL be combinational: rsN_tag = spec_map[rsN_idx]; rd_old_tag = spec_map[rd_idx]; commit_old_tag = committed_map[commit_idx].
REQ-005 Sources SHALL read the map before a same-cycle rename: rs_idx == rd_idx with rename_valid returns the old tag.
REQ-006 rsN_ready and rsN_data SHALL bypass same-cycle writeback: if any wb_valid[p] has wb_tag[p] == rsN_tag, then ready=1 and data=wb_data[p], highest p winning.
REQ-007 Index 0 SHALL read tag 0, ready 1, and data 0 at all times.
REQ-008 On posedge with rename_valid && rd_idx!=0 && !flush, the module SHALL set spec_map[rd_idx] <= rd_new_tag and ready[rd_new_tag] <= 0; rd_idx==0 SHALL be a no-op.
REQ-009 On posedge, for each wb_valid[p] with wb_tag[p]!=0, the module SHALL set data[wb_tag[p]] <= wb_data[p] and ready[wb_tag[p]] <= 1; writeback has 1-cycle latency to a non-bypassed read.
REQ-010 Multiple ports writing the same tag SHALL resolve with the highest port index winning for data.
REQ-011 A rename clear and a writeback set to the same tag in the same cycle SHALL leave ready=0, with the rename taking priority.
REQ-012 On posedge with commit_valid && commit_idx!=0, the module SHALL set committed_map[commit_idx] <= commit_tag.
REQ-013 On posedge with flush, the module SHALL set spec_map to the committed map including any same-cycle commit, ignore rename_valid, and still perform writebacks.
REQ-014 Ready and data SHALL never be altered by flush.

Reset
REQ-015 While rst is high at posedge, both maps SHALL be set to identity (entry i = i), all ready bits to 1, and all data to 0; rename, writeback, commit and flush SHALL be ignored.
REQ-016 Combinational outputs after reset SHALL reflect the reset state: rsN_tag = rsN_idx, ready=1, data=0, commit_old_tag = commit_idx.

Structure
REQ-017 Width and depth constants and the wb packing helpers SHALL live in the shared package ooo_pkg.
REQ-018 One sub-module, map_bank (NUM_AREG x PREG_WIDTH table, sync write, async read, bulk load, identity reset), SHALL be instantiated twice, for speculative and committed.

Verification
REQ-019 Scenario: reset, then read rs1_idx=5 -> rs1_tag=5, rs1_ready=1, rs1_data=0.
REQ-020 Scenario: rename rd_idx=3 to tag 40; next cycle rs1_idx=3 -> tag 40, ready 0; wb tag 40 data 0xDEADBEEF in the same cycle as the read -> ready 1, data 0xDEADBEEF combinationally.
REQ-021 Scenario: wb port0 and port1 both target tag 41 (0x1, 0x2) -> data[41]=0x2 next cycle; rename tag 42 with wb tag 42 in the same cycle -> ready[42]=0.
REQ-022 Scenario: rename x7->50, then x7->51; commit x7 tag 50 -> commit_old_tag=7; flush -> rs1_idx=7 reads tag 50.
REQ-023 Scenario: rename rd_idx=0 to tag 60 and wb to tag 0 -> x0 stays tag 0, data 0, and ready[60] stays 1.
REQ-024 Scenario: rst asserted mid-sequence with rename and wb active -> next cycle identity maps, all ready, data 0.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared widths/depths for the rename stage and helpers that unpack the
// per-port writeback buses (port 0 in the LSBs).
package ooo_pkg;
    localparam int AREG_WIDTH = 5;
    localparam int NUM_AREG   = 32;
    localparam int PREG_WIDTH = 6;
    localparam int NUM_PREG   = 64;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WB     = 2;

    function automatic logic [PREG_WIDTH-1:0] wb_tag_at(
        input logic [NUM_WB*PREG_WIDTH-1:0] tags,
        input int                           port
    );
        return tags[port*PREG_WIDTH +: PREG_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wb_data_at(
        input logic [NUM_WB*DATA_WIDTH-1:0] data,
        input int                           port
    );
        return data[port*DATA_WIDTH +: DATA_WIDTH];
    endfunction
endpackage

// File: rtl/map_bank.sv
// Arch-to-phys mapping table: identity on reset, bulk load beats single write,
// whole table exposed for asynchronous reads.
module map_bank #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5,
    parameter int W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             load,
    input  logic [W-1:0]     load_data [DEPTH],
    output logic [W-1:0]     entries   [DEPTH]
);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= W'(i);
            end
        end else if (load) begin
            entries <= load_data;
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/rename_map_table.sv
// Register rename map: speculative and committed maps plus per-phys-tag
// ready/data, with same-cycle writeback bypass on the source read ports.
module rename_map_table
    import ooo_pkg::*;
#(
    parameter int AREG_WIDTH = ooo_pkg::AREG_WIDTH,
    parameter int NUM_AREG   = ooo_pkg::NUM_AREG,
    parameter int PREG_WIDTH = ooo_pkg::PREG_WIDTH,
    parameter int NUM_PREG   = ooo_pkg::NUM_PREG,
    parameter int DATA_WIDTH = ooo_pkg::DATA_WIDTH,
    parameter int NUM_WB     = ooo_pkg::NUM_WB
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AREG_WIDTH-1:0]        rs1_idx,
    input  logic [AREG_WIDTH-1:0]        rs2_idx,
    input  logic [AREG_WIDTH-1:0]        rd_idx,
    input  logic                         rename_valid,
    input  logic [PREG_WIDTH-1:0]        rd_new_tag,
    output logic [PREG_WIDTH-1:0]        rs1_tag,
    output logic [PREG_WIDTH-1:0]        rs2_tag,
    output logic [PREG_WIDTH-1:0]        rd_old_tag,
    output logic                         rs1_ready,
    output logic                         rs2_ready,
    output logic [DATA_WIDTH-1:0]        rs1_data,
    output logic [DATA_WIDTH-1:0]        rs2_data,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0] wb_tag,
    input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
    input  logic                         commit_valid,
    input  logic [AREG_WIDTH-1:0]        commit_idx,
    input  logic [PREG_WIDTH-1:0]        commit_tag,
    output logic [PREG_WIDTH-1:0]        commit_old_tag,
    input  logic                         flush
);
    logic [PREG_WIDTH-1:0] spec_q    [NUM_AREG];
    logic [PREG_WIDTH-1:0] comm_q    [NUM_AREG];
    logic [PREG_WIDTH-1:0] comm_next [NUM_AREG];
    logic [NUM_PREG-1:0]   ready_q;
    logic [DATA_WIDTH-1:0] data_q    [NUM_PREG];

    logic spec_we;
    logic comm_we;
    assign spec_we = rename_valid && (rd_idx != '0);
    assign comm_we = commit_valid && (commit_idx != '0);

    // Flush restores from the committed map as it will look after this edge.
    always_comb begin
        comm_next = comm_q;
        if (comm_we) comm_next[commit_idx] = commit_tag;
    end

    map_bank #(.DEPTH(NUM_AREG), .IDX_W(AREG_WIDTH), .W(PREG_WIDTH)) u_spec_map (
        .clk       (clk),
        .rst       (rst),
        .we        (spec_we),
        .waddr     (rd_idx),
        .wdata     (rd_new_tag),
        .load      (flush),
        .load_data (comm_next),
        .entries   (spec_q)
    );

    map_bank #(.DEPTH(NUM_AREG), .IDX_W(AREG_WIDTH), .W(PREG_WIDTH)) u_comm_map (
        .clk       (clk),
        .rst       (rst),
        .we        (comm_we),
        .waddr     (commit_idx),
        .wdata     (commit_tag),
        .load      (1'b0),
        .load_data (comm_q),
        .entries   (comm_q)
    );

    // Rename clear is written last so it overrides a same-tag writeback set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= '1;
            for (int i = 0; i < NUM_PREG; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && (wb_tag_at(wb_tag, p) != '0)) begin
                    data_q[wb_tag_at(wb_tag, p)]  <= wb_data_at(wb_data, p);
                    ready_q[wb_tag_at(wb_tag, p)] <= 1'b1;
                end
            end
            if (spec_we && !flush) ready_q[rd_new_tag] <= 1'b0;
        end
    end

    logic [AREG_WIDTH-1:0] src_idx  [2];
    logic [PREG_WIDTH-1:0] src_tag  [2];
    logic                  src_rdy  [2];
    logic [DATA_WIDTH-1:0] src_data [2];

    assign src_idx[0] = rs1_idx;
    assign src_idx[1] = rs2_idx;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_tag[s]  = spec_q[src_idx[s]];
            src_rdy[s]  = ready_q[src_tag[s]];
            src_data[s] = data_q[src_tag[s]];
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && (wb_tag_at(wb_tag, p) == src_tag[s])) begin
                    src_rdy[s]  = 1'b1;
                    src_data[s] = wb_data_at(wb_data, p);
                end
            end
            if (src_idx[s] == '0) begin
                src_tag[s]  = '0;
                src_rdy[s]  = 1'b1;
                src_data[s] = '0;
            end
        end
    end

    assign rs1_tag        = src_tag[0];
    assign rs2_tag        = src_tag[1];
    assign rs1_ready      = src_rdy[0];
    assign rs2_ready      = src_rdy[1];
    assign rs1_data       = src_data[0];
    assign rs2_data       = src_data[1];
    assign rd_old_tag     = spec_q[rd_idx];
    assign commit_old_tag = comm_q[commit_idx];
endmodule

// File: tb/tb_rename_map_table.sv
// Directed vector table for the named scenarios, then randomized traffic
// compared against an array-based reference model of the rename map.
module tb_rename_map_table;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        rename_valid;
    logic [5:0]  rd_new_tag;
    logic [5:0]  rs1_tag, rs2_tag, rd_old_tag;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_data, rs2_data;
    logic [1:0]  wb_valid;
    logic [5:0]  wb_t [2];
    logic [31:0] wb_d [2];
    logic [11:0] wb_tag;
    logic [63:0] wb_data;
    logic        commit_valid;
    logic [4:0]  commit_idx;
    logic [5:0]  commit_tag;
    logic [5:0]  commit_old_tag;
    logic        flush;

    assign wb_tag  = {wb_t[1], wb_t[0]};
    assign wb_data = {wb_d[1], wb_d[0]};

    always #5 clk = ~clk;

    rename_map_table dut (
        .clk(clk), .rst(rst),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rename_valid(rename_valid), .rd_new_tag(rd_new_tag),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd_old_tag(rd_old_tag),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_tag(commit_tag),
        .commit_old_tag(commit_old_tag), .flush(flush)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays updated from the architectural rules.
    logic [5:0]  spec_m [32];
    logic [5:0]  comm_m [32];
    bit          rdy_m  [64];
    logic [31:0] dat_m  [64];

    function automatic logic [5:0] m_tag(input logic [4:0] idx);
        return (idx == 0) ? 6'd0 : spec_m[idx];
    endfunction

    function automatic logic m_rdy(input logic [4:0] idx);
        logic r;
        if (idx == 0) return 1'b1;
        r = rdy_m[m_tag(idx)];
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && wb_t[p] == m_tag(idx)) r = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_dat(input logic [4:0] idx);
        logic [31:0] d;
        if (idx == 0) return 32'd0;
        d = dat_m[m_tag(idx)];
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && wb_t[p] == m_tag(idx)) d = wb_d[p];
        return d;
    endfunction

    task automatic model_step();
        logic [5:0] comm_n [32];
        if (rst) begin
            for (int i = 0; i < 32; i++) begin spec_m[i] = 6'(i); comm_m[i] = 6'(i); end
            for (int i = 0; i < 64; i++) begin rdy_m[i] = 1'b1; dat_m[i] = 32'd0; end
        end else begin
            comm_n = comm_m;
            if (commit_valid && commit_idx != 0) comm_n[commit_idx] = commit_tag;
            for (int p = 0; p < 2; p++)
                if (wb_valid[p] && wb_t[p] != 0) begin
                    dat_m[wb_t[p]] = wb_d[p];
                    rdy_m[wb_t[p]] = 1'b1;
                end
            if (flush) spec_m = comm_n;
            else if (rename_valid && rd_idx != 0) begin
                spec_m[rd_idx] = rd_new_tag;
                rdy_m[rd_new_tag] = 1'b0;
            end
            comm_m = comm_n;
        end
    endtask

    typedef struct {
        bit          chk;
        bit          rst;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        bit          rv;
        logic [5:0]  nt;
        logic [1:0]  wbv;
        logic [5:0]  t0;
        logic [31:0] d0;
        logic [5:0]  t1;
        logic [31:0] d1;
        bit          cv;
        logic [4:0]  ci;
        logic [5:0]  ct;
        bit          fl;
        logic [5:0]  e_tag;
        bit          e_rdy;
        logic [31:0] e_dat;
        logic [5:0]  e_cold;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    initial begin
        //              chk rst rs1 rd rv nt wbv t0 d0 t1 d1 cv ci ct fl | tag rdy dat cold
        tbl[0]  = '{0, 1, 0, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0,  0, 1, 0,            0};
        tbl[1]  = '{1, 0, 5, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0,  5, 1, 0,            0};
        tbl[2]  = '{1, 0, 3, 3, 1, 40, 0,  0, 0,            0, 0, 0, 0, 0,  0,  3, 1, 0,            0};
        tbl[3]  = '{1, 0, 3, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 40, 0, 0,            0};
        tbl[4]  = '{1, 0, 3, 0, 0, 0,  1, 40, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 40, 1, 32'hDEADBEEF, 0};
        tbl[5]  = '{1, 0, 3, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 40, 1, 32'hDEADBEEF, 0};
        tbl[6]  = '{1, 0, 0, 4, 1, 41, 0,  0, 0,            0, 0, 0, 0, 0,  0,  0, 1, 0,            0};
        tbl[7]  = '{1, 0, 4, 0, 0, 0,  3, 41, 1,           41, 2, 0, 0, 0,  0, 41, 1, 2,            0};
        tbl[8]  = '{1, 0, 4, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 41, 1, 2,            0};
        tbl[9]  = '{1, 0, 5, 5, 1, 42, 1, 42, 32'h55,       0, 0, 0, 0, 0,  0,  5, 1, 0,            0};
        tbl[10] = '{1, 0, 5, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 42, 0, 32'h55,       0};
        tbl[11] = '{1, 0, 0, 7, 1, 50, 0,  0, 0,            0, 0, 0, 0, 0,  0,  0, 1, 0,            0};
        tbl[12] = '{1, 0, 7, 7, 1, 51, 0,  0, 0,            0, 0, 0, 0, 0,  0, 50, 0, 0,            0};
        tbl[13] = '{1, 0, 7, 0, 0, 0,  0,  0, 0,            0, 0, 1, 7, 50, 0, 51, 0, 0,            7};
        tbl[14] = '{1, 0, 7, 0, 0, 0,  0,  0, 0,            0, 0, 0, 7, 0,  1, 51, 0, 0,           50};
        tbl[15] = '{1, 0, 7, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 50, 0, 0,            0};
        tbl[16] = '{1, 0, 0, 8, 1, 52, 0,  0, 0,            0, 0, 0, 0, 0,  0,  0, 1, 0,            0};
        tbl[17] = '{1, 0, 8, 9, 1, 53, 0,  0, 0,            0, 0, 1, 8, 52, 1, 52, 0, 0,            8};
        tbl[18] = '{1, 0, 8, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0, 52, 0, 0,            0};
        tbl[19] = '{1, 0, 9, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0,  9, 1, 0,            0};
        tbl[20] = '{1, 0, 0, 0, 1, 60, 1,  0, 32'h1234,     0, 0, 0, 0, 0,  0,  0, 1, 0,            0};
        tbl[21] = '{1, 0, 0, 0, 0, 0,  0,  0, 0,            0, 0, 1, 10, 60, 1, 0, 1, 0,           10};
        tbl[22] = '{1, 0, 10, 0, 0, 0, 0,  0, 0,            0, 0, 0, 0, 0,  0, 60, 1, 0,            0};
        tbl[23] = '{1, 1, 3, 3, 1, 44, 1,  3, 32'h99,       0, 0, 0, 0, 0,  0,  3, 1, 32'h99,       0};
        tbl[24] = '{1, 0, 3, 0, 0, 0,  0,  0, 0,            0, 0, 0, 7, 0,  0,  3, 1, 0,            7};
        tbl[25] = '{1, 0, 7, 0, 0, 0,  0,  0, 0,            0, 0, 0, 0, 0,  0,  7, 1, 0,            0};

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; rs1_idx = tbl[i].rs1; rs2_idx = 5'd0; rd_idx = tbl[i].rd;
            rename_valid = tbl[i].rv; rd_new_tag = tbl[i].nt; wb_valid = tbl[i].wbv;
            wb_t[0] = tbl[i].t0; wb_d[0] = tbl[i].d0; wb_t[1] = tbl[i].t1; wb_d[1] = tbl[i].d1;
            commit_valid = tbl[i].cv; commit_idx = tbl[i].ci; commit_tag = tbl[i].ct;
            flush = tbl[i].fl;
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("row%0d rs1_tag", i), 32'(rs1_tag), 32'(tbl[i].e_tag));
                check($sformatf("row%0d rs1_ready", i), 32'(rs1_ready), 32'(tbl[i].e_rdy));
                check($sformatf("row%0d rs1_data", i), rs1_data, tbl[i].e_dat);
                check($sformatf("row%0d commit_old_tag", i), 32'(commit_old_tag), 32'(tbl[i].e_cold));
            end
            @(posedge clk);
            model_step();
            #1;
        end

        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            rs1_idx = 5'($urandom_range(0, 31));
            rs2_idx = ($urandom_range(0, 3) == 0) ? rd_idx : 5'($urandom_range(0, 31));
            rd_idx = 5'($urandom_range(0, 31));
            rename_valid = $urandom_range(0, 1) == 1;
            rd_new_tag = 6'($urandom_range(1, 63));
            for (int p = 0; p < 2; p++) begin
                wb_valid[p] = $urandom_range(0, 2) != 0;
                wb_t[p] = ($urandom_range(0, 1) == 1) ? spec_m[$urandom_range(0, 31)]
                                                      : 6'($urandom_range(0, 63));
                wb_d[p] = $urandom;
            end
            commit_valid = $urandom_range(0, 2) == 0;
            commit_idx = 5'($urandom_range(0, 31));
            commit_tag = 6'($urandom_range(1, 63));
            flush = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            check("rnd rs1_tag", 32'(rs1_tag), 32'(m_tag(rs1_idx)));
            check("rnd rs2_tag", 32'(rs2_tag), 32'(m_tag(rs2_idx)));
            check("rnd rd_old_tag", 32'(rd_old_tag), 32'(spec_m[rd_idx]));
            check("rnd rs1_ready", 32'(rs1_ready), 32'(m_rdy(rs1_idx)));
            check("rnd rs2_ready", 32'(rs2_ready), 32'(m_rdy(rs2_idx)));
            check("rnd rs1_data", rs1_data, m_dat(rs1_idx));
            check("rnd rs2_data", rs2_data, m_dat(rs2_idx));
            check("rnd commit_old_tag", 32'(commit_old_tag), 32'(comm_m[commit_idx]));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
